// File: rtl/frame_buffer_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_writer_pkg
// Purpose  : Shared types and defaults for the frame buffer writer slice.
//            Holds the sequencer state enum, the data-mode enum, a raw-mode
//            decoder, and the default frame geometry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package frame_buffer_writer_pkg;

  localparam int FRAME_LEN_DEF = 384000;
  localparam int PRESCALE_DEF  = 16;
  localparam int MARK_MOD_DEF  = 50;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_MARK  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_CONST = 2'd2
  } mode_e;

  // The reserved encoding 3 behaves as marker mode, so it is folded here once
  // and the rest of the datapath only ever sees legal enum values.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'd1:    m = MODE_RAMP;
      2'd2:    m = MODE_CONST;
      default: m = MODE_MARK;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_buffer_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_writer_if
// Purpose  : Valid/ready write port between the frame buffer writer and the
//            sample RAM.
// Signals  : wr_valid (writer->RAM) write request
//            wr_addr  (writer->RAM) write address, ADDR_W bits
//            wr_data  (writer->RAM) write data, DATA_W bits
//            wr_ready (RAM->writer) write accepted when valid && ready
// Modports : master (writer side), slave (RAM side)
// Revision : 1.0 - initial release
// ============================================================================
interface frame_buffer_writer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface
`default_nettype wire

// File: rtl/frame_buffer_writer_data_gen.sv
`default_nettype none
// ============================================================================
// Module   : frame_data_gen
// Purpose  : Maps (mode, address, constant) to the write data word and
//            registers it alongside the address register in the top level.
//            Marker mode emits all-ones when addr % MARK_MOD == 0, ramp mode
//            emits the address resized to DATA_W, constant mode emits the
//            latched constant.
// Ports    : clk      in  clock, rising edge
//            reset_n  in  asynchronous active-low reset
//            i_load   in  capture a new data word this cycle
//            i_mode   in  data mode (already decoded)
//            i_addr   in  address of the write being issued
//            i_const  in  latched constant for constant mode
//            o_data   out registered write data
// Revision : 1.0 - initial release
// ============================================================================
module frame_data_gen
  import frame_buffer_writer_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MARK_MOD = MARK_MOD_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  mode_e             i_mode,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_const,
  output logic [DATA_W-1:0] o_data
);

  // The modulo runs at least 32 bits wide so a MARK_MOD larger than the
  // address range still compares correctly (only address 0 is a marker).
  localparam int c_mw = (ADDR_W > 32) ? ADDR_W : 32;

  logic [c_mw-1:0]   w_addr_ext;
  logic              w_is_mark;
  logic [DATA_W-1:0] w_ramp;
  logic [DATA_W-1:0] w_data_nxt;
  logic [DATA_W-1:0] r_data;

  assign w_addr_ext = c_mw'(i_addr);
  assign w_is_mark  = ((w_addr_ext % c_mw'(MARK_MOD)) == '0);

  if (DATA_W >= ADDR_W) begin : g_ramp_wide
    assign w_ramp = DATA_W'(i_addr);
  end else begin : g_ramp_narrow
    assign w_ramp = i_addr[DATA_W-1:0];
  end

  always_comb begin
    w_data_nxt = '0;
    case (i_mode)
      MODE_RAMP:  w_data_nxt = w_ramp;
      MODE_CONST: w_data_nxt = i_const;
      default:    w_data_nxt = w_is_mark ? '1 : '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= w_data_nxt;
    end
  end

  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/frame_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_writer
// Purpose  : Walks a frame of FRAME_LEN ticks and issues one RAM write every
//            PRESCALE ticks over a valid/ready port, with start/abort/done
//            control and marker/ramp/constant data modes.
// Ports    : clk        in  clock, rising edge
//            reset_n    in  asynchronous active-low reset
//            start      in  begin a frame (honoured in IDLE only)
//            abort      in  terminate the frame, highest priority
//            mode       in  data mode, sampled with start
//            const_data in  constant-mode data, sampled with start
//            wr         --  write port (master modport)
//            busy       out high while in RUN
//            done       out one-cycle pulse at normal frame completion
// Revision : 1.0 - initial release
// ============================================================================
module frame_buffer_writer
  import frame_buffer_writer_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 33,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int PRESCALE  = PRESCALE_DEF,
  parameter int MARK_MOD  = MARK_MOD_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           mode,
  input  logic [DATA_W-1:0]    const_data,
  frame_buffer_writer_if.master wr,
  output logic                 busy,
  output logic                 done
);

  localparam int               c_writes   = FRAME_LEN / PRESCALE;
  localparam int               c_pre_sh   = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] c_last     = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] c_pre_mask = CNT_W'(PRESCALE - 1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (PRESCALE < 1 || (PRESCALE & (PRESCALE - 1)) != 0) begin : g_chk_prescale
    $error("frame_buffer_writer: PRESCALE must be a power of two >= 1");
  end

  if (FRAME_LEN < 1 || (FRAME_LEN % PRESCALE) != 0) begin : g_chk_frame
    $error("frame_buffer_writer: FRAME_LEN must be a positive multiple of PRESCALE");
  end

  if (MARK_MOD < 1) begin : g_chk_mark
    $error("frame_buffer_writer: MARK_MOD must be at least 1");
  end

  if (CNT_W < 63 && longint'(FRAME_LEN) >= (longint'(1) << CNT_W)) begin : g_chk_cnt
    $error("frame_buffer_writer: FRAME_LEN does not fit in CNT_W");
  end

  if (ADDR_W < 62 && longint'(c_writes) > (longint'(1) << ADDR_W)) begin : g_warn_wrap
    $warning("frame_buffer_writer: writes per frame exceed 2**ADDR_W, addresses wrap");
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  // Set when the counter has finished its walk but the final write (only
  // possible with PRESCALE == 1) is still on the bus waiting for acceptance.
  logic              r_tail;
  logic              w_tail_nxt;
  logic [ADDR_W-1:0] r_addr;
  mode_e             r_mode;
  logic [DATA_W-1:0] r_const;

  logic              w_stall;
  logic              w_issue;
  logic              w_at_end;
  logic              w_load;
  logic              w_latch;
  logic [ADDR_W-1:0] w_next_addr;
  logic [DATA_W-1:0] w_data;

  assign w_stall     = r_valid & ~wr.wr_ready;
  assign w_issue     = ((r_cnt & c_pre_mask) == '0);
  assign w_at_end    = (r_cnt == c_last);
  assign w_next_addr = ADDR_W'(r_cnt >> c_pre_sh);

  // --------------------------------------------------------------------------
  // FSM: next state, counter and handshake control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_tail_nxt  = r_tail;
    w_load      = 1'b0;
    w_latch     = 1'b0;

    case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        w_tail_nxt  = 1'b0;
        if (start && !abort) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
          w_latch     = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_tail_nxt  = 1'b0;
        end else if (r_tail) begin
          // Counter is done; finish once the last write is accepted.
          if (!w_stall) begin
            w_state_nxt = DONE;
            w_valid_nxt = 1'b0;
            w_tail_nxt  = 1'b0;
          end
        end else if (!w_stall) begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_valid_nxt = w_issue;
          w_load      = w_issue;
          if (w_at_end) begin
            if (w_issue) begin
              w_tail_nxt = 1'b1;
            end else begin
              w_state_nxt = DONE;
            end
          end
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_tail_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_tail_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_tail  <= 1'b0;
      r_addr  <= '0;
      r_mode  <= MODE_MARK;
      r_const <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_tail  <= w_tail_nxt;
      if (w_load) begin
        r_addr <= w_next_addr;
      end
      if (w_latch) begin
        r_mode  <= decode_mode(mode);
        r_const <= const_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Data word generation, registered in step with r_addr
  // --------------------------------------------------------------------------
  frame_data_gen #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MARK_MOD (MARK_MOD)
  ) u_data_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_mode  (r_mode),
    .i_addr  (w_next_addr),
    .i_const (r_const),
    .o_data  (w_data)
  );

  assign wr.wr_valid = r_valid;
  assign wr.wr_addr  = r_addr;
  assign wr.wr_data  = w_data;
  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_buffer_writer
// Purpose  : Self-checking bench for frame_buffer_writer. Each frame's writes
//            are compared against a reference write list built from the
//            address/mode rules, and frame timing against FRAME_LEN plus the
//            number of stalled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_writer;
  import frame_buffer_writer_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 33;
  localparam int FRAME_LEN = 64;
  localparam int PRESCALE  = 4;
  localparam int MARK_MOD  = 5;
  localparam int NWR       = FRAME_LEN / PRESCALE;
  localparam int STALL_AT  = 2 + PRESCALE * 6;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [DATA_W-1:0] const_data = '0;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  frame_buffer_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

  frame_buffer_writer #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .FRAME_LEN (FRAME_LEN),
    .PRESCALE  (PRESCALE),
    .MARK_MOD  (MARK_MOD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .const_data (const_data),
    .wr         (wr_if),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference data word for a write at address a in mode md (3 acts as 0).
  function automatic logic [7:0] ref_data(input int md, input int a, input logic [7:0] c);
    if (md == 1) return 8'(a);
    if (md == 2) return c;
    return ((a % MARK_MOD) == 0) ? 8'hFF : 8'h00;
  endfunction

  // ready_kind: 0 always ready, 1 random ready, 2 ready low 3 cycles at addr 6
  task automatic run_frame(input int md, input logic [7:0] cd, input int ready_kind,
                           input int abort_addr, input bit poke_start);
    int cyc, nw, stalls, busy_cyc, done_cyc, dpulse;
    bit prev_stall, aborted;
    @(negedge clk);
    start = 1'b1;
    mode = 2'(md);
    const_data = cd;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'($urandom);
    const_data = cd ^ 8'h99;
    cyc = 0; nw = 0; stalls = 0; busy_cyc = 0; done_cyc = 0;
    prev_stall = 1'b0; aborted = 1'b0;
    while (done_cyc == 0 && !aborted && cyc < 4 * FRAME_LEN) begin
      case (ready_kind)
        1:       wr_if.wr_ready = ($urandom_range(0, 3) != 0);
        2:       wr_if.wr_ready = !((cyc + 1) >= STALL_AT && (cyc + 1) <= STALL_AT + 2);
        default: wr_if.wr_ready = 1'b1;
      endcase
      start = (poke_start && (cyc + 1) == 20);
      @(negedge clk);
      cyc++;
      if (busy) busy_cyc++;
      if (done) done_cyc = cyc;
      if (wr_if.wr_valid) begin
        if (!prev_stall)
          check_value("first_cycle", 64'(cyc), 64'(2 + PRESCALE * nw + stalls));
        if (abort_addr >= 0 && int'(wr_if.wr_addr) == abort_addr) begin
          abort = 1'b1;
          aborted = 1'b1;
        end
        if (wr_if.wr_ready) begin
          check_value("wr_addr", 64'(wr_if.wr_addr), 64'(nw % 256));
          check_value("wr_data", 64'(wr_if.wr_data), 64'(ref_data(md, nw % 256, cd)));
          nw++;
          prev_stall = 1'b0;
        end else begin
          stalls++;
          prev_stall = 1'b1;
        end
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
    end
    wr_if.wr_ready = 1'b1;
    if (aborted) begin
      @(negedge clk);
      check_value("abort_outputs", 64'({wr_if.wr_valid, busy, done}), 64'(0));
      check_value("abort_writes", 64'(nw), 64'(abort_addr + 1));
      dpulse = 0;
      repeat (4) begin
        @(negedge clk);
        if (done) dpulse++;
      end
      check_value("abort_no_done", 64'(dpulse), 64'(0));
    end else begin
      check_value("done_seen", 64'(done_cyc != 0), 64'(1));
      check_value("write_count", 64'(nw), 64'(NWR));
      check_value("done_cycle", 64'(done_cyc), 64'(FRAME_LEN + stalls + 1));
      check_value("busy_cycles", 64'(busy_cyc), 64'(FRAME_LEN + stalls));
      if (ready_kind == 2) check_value("stall_cycles", 64'(stalls), 64'(3));
      @(negedge clk);
      check_value("after_done", 64'({done, busy, wr_if.wr_valid}), 64'(0));
    end
  endtask

  initial begin
    bit found;
    wr_if.wr_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_valid", 64'(wr_if.wr_valid), 64'(0));
    check_value("rst_addr", 64'(wr_if.wr_addr), 64'(0));
    check_value("rst_data", 64'(wr_if.wr_data), 64'(0));
    check_value("rst_busy", 64'(busy), 64'(0));
    check_value("rst_done", 64'(done), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_frame(0, 8'($urandom), 0, -1, 1'b0);
    run_frame(1, 8'($urandom), 2, -1, 1'b0);
    run_frame(2, 8'hA5, 0, -1, 1'b0);
    run_frame(1, 8'($urandom), 0, 9, 1'b0);
    run_frame(3, 8'($urandom), 0, -1, 1'b0);

    // start together with abort in IDLE must not launch a frame
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_value("start_abort_idle", 64'({busy, wr_if.wr_valid, done}), 64'(0));
    end

    run_frame(int'($urandom_range(0, 3)), 8'($urandom), 0, -1, 1'b1);

    // asynchronous reset between edges while a write is on the bus
    @(negedge clk);
    start = 1'b1;
    mode = 2'd2;
    const_data = 8'hA5;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (wr_if.wr_valid && wr_if.wr_addr == 8'd3) found = 1'b1;
    end
    check_value("reset_target_found", 64'(found), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check_value("async_rst_outputs",
                64'({wr_if.wr_valid, busy, done, wr_if.wr_addr, wr_if.wr_data}), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_frame(1, 8'($urandom), 0, -1, 1'b0);

    for (int f = 0; f < 6; f++) begin
      run_frame(int'($urandom_range(0, 3)), 8'($urandom), 1, -1, bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Parametrised successor to the fixed-rate buffer-fill sequencer. Walks a sample frame of FRAME_LEN clock ticks and emits one buffer write every PRESCALE ticks, with a valid/ready write port.
- Adds start/abort/done control, back-pressure, and three data modes: marker, ramp and constant.
- Sits between the control FSM and the sample RAM write port.

Parameters:
- ADDR_W, 16, width of the write address.
- DATA_W, 16, width of the write data.
- CNT_W, 33, width of the tick counter.
- FRAME_LEN, 384000, ticks per frame; must be a multiple of PRESCALE.
- PRESCALE, 16, ticks per write; must be a power of two, at least 1.
- MARK_MOD, 50, marker modulus used in mode 0; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- abort  in  1  terminates the frame; takes priority over all other activity.
- mode  in  2  0 = marker, 1 = ramp, 2 = constant, 3 = reserved (behaves as 0); sampled on the start cycle.
- const_data  in  DATA_W  data used in mode 2; sampled on the start cycle.
- wr_valid  out  1  write request.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- wr_ready  in  1  the RAM accepts the write when wr_valid and wr_ready are both high.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at normal frame completion.

Behaviour:
- Reset (asynchronous assert, synchronous deassert expected upstream): state IDLE; counter 0; wr_valid, busy and done 0; wr_addr 0; wr_data 0; latched mode 0; latched const 0.
- States are IDLE, RUN and DONE.
- IDLE to RUN: on start. Latch mode and const_data, clear the counter. busy goes high the next cycle.
- RUN, per cycle:
  - Stall when wr_valid=1 and wr_ready=0: the counter, wr_addr and wr_data hold. wr_valid must not drop while stalled except on abort.
  - Otherwise the counter increments by 1.
  - When counter % PRESCALE == 0 (low log2(PRESCALE) bits zero), the next cycle presents wr_valid=1, wr_addr = (counter / PRESCALE) truncated to ADDR_W, and wr_data per mode.
  - Mode 0: all-ones if (wr_addr % MARK_MOD) == 0, else 0.
  - Mode 1: wr_addr zero-extended or truncated to DATA_W.
  - Mode 2: the latched const_data.
  - wr_valid clears after the handshake unless a new write is due.
- Write latency: one cycle from a qualifying counter value to wr_valid.
- Writes per frame: FRAME_LEN / PRESCALE, at addresses 0 .. FRAME_LEN/PRESCALE - 1.
- If FRAME_LEN/PRESCALE exceeds 2^ADDR_W, addresses wrap modulo 2^ADDR_W. This is legal but flagged by an elaboration warning.
- RUN to DONE: when the counter reaches FRAME_LEN - 1 and advances, and the last write has handshaken. If the last write is stalled, remain in RUN until it is accepted.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- abort in RUN or DONE: next cycle IDLE, wr_valid=0, counter=0, and no done pulse. abort in IDLE has no effect.
- abort and start in the same cycle: abort wins; state stays IDLE.
- start while in RUN or DONE is ignored; it is not queued.
- All arithmetic is unsigned. The counter compare uses a CNT_W-wide constant, and FRAME_LEN must fit in CNT_W.
- Reset in mid-frame drops everything immediately (asynchronous); there is no partial done.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - the mode enum (MODE_MARK, MODE_RAMP, MODE_CONST);
  - the defaults FRAME_LEN_DEF=384000, PRESCALE_DEF=16, MARK_MOD_DEF=50.
- One natural sub-module: frame_data_gen, a combinational-plus-register stage that maps (mode, addr, const) to wr_data and contains the MARK_MOD modulo.
- The top level holds the FSM, counter and handshake.

Test Plan:
Bench parameters: FRAME_LEN=64, PRESCALE=4, MARK_MOD=5, ADDR_W=8, DATA_W=8, wr_ready=1 unless stated.
- Mode 0, one start -> 16 writes at addr 0..15. Data is 0xFF at addr 0, 5, 10 and 15, and 0x00 elsewhere. wr_valid rises 1 cycle after the counter hits 0, 4, 8, ... A single done pulse follows; busy is high throughout RUN.
- Mode 1 with wr_ready held low for 3 cycles at addr 6 -> wr_valid, addr 6 and data 6 hold for 3 extra cycles. The counter freezes, total writes stay at 16, and done arrives 3 cycles later than in the unstalled run.
- Mode 2, const_data=0xA5, const_data changed to 0x3C mid-frame -> all 16 writes carry 0xA5.
- abort at addr 9 -> next cycle wr_valid=0 and busy=0, with no done pulse. A fresh start then restarts at addr 0.
- reset_n asserted low mid-write, asynchronously between edges -> outputs go to their reset values immediately, before the next clk edge.
- start during RUN, plus start and abort asserted together in IDLE -> both are ignored: there is no restart and the frame write count is unchanged.
